tick_divider_bank: RTL and testbench
====================================

// Module: tick_divider_bank
// PURPOSE
//  Bank of NUM_CH independent programmable clock-enable dividers driven from i_clk.
//  Each channel emits a one-cycle tick per period and a duty-programmable square
//  wave. Feeds peripheral timing (UART baud, LED PWM, sample strobes).
//  Generalised successor to the single-channel tick divider: per-channel enable,
//  glitch-free period reload, duty control and bank-wide phase sync.
// PARAMETERS
//  NUM_CH  4   number of divider channels (1..16)
//  CNT_W   24  counter / period / duty width in bits (2..32)
// PORTS
//  i_clk     in   1             system clock; all logic on posedge
//  i_reset   in   1             reset; asynchronous, active-high
//  i_enable  in   NUM_CH        per-channel run enable, level
//  i_period  in   NUM_CH*CNT_W  per-channel terminal count P, ch n at [n*CNT_W +: CNT_W]
//  i_high    in   NUM_CH*CNT_W  per-channel wave high-time H, same packing
//  i_sync    in   1             one-cycle pulse: restart all running channels at phase 0
//  o_tick    out  NUM_CH        one-cycle pulse at terminal count
//  o_wave    out  NUM_CH        square wave, high for H of every P+1 cycles
// BEHAVIOUR
//  - Reset: all counters 0, shadow P/H 0, FSMs IDLE, o_tick=0, o_wave=0.
//  - Per-channel FSM: IDLE -> RUN when i_enable[n]=1; RUN -> IDLE when i_enable[n]=0.
//    IDLE: counter held 0, o_tick=0, o_wave=0.
//  - On IDLE->RUN edge: shadow_P<=i_period, shadow_H<=i_high, counter<=0.
//  - RUN: counter counts 0..shadow_P then wraps to 0; period = shadow_P+1 cycles.
//  - o_tick registered: high exactly the cycle after counter==shadow_P edge, i.e.
//    first tick P+1 cycles after the edge that sampled enable high; then every P+1.
//  - o_wave registered: 1 while counter < shadow_H. H=0 -> constant 0;
//    H>=P+1 -> constant 1 while RUN.
//  - Reload: i_period/i_high sampled into shadow only on wrap (counter==shadow_P);
//    mid-period changes never truncate or stretch the current period.
//  - P=0: divide-by-1, o_tick high every RUN cycle; o_wave per H rule.
//  - Width: unsigned CNT_W compare; counter never exceeds shadow_P; no overflow.
//  - i_sync: every RUN channel reloads shadows and sets counter<=0 that edge, no tick
//    issued on that edge; IDLE channels unaffected. Sync wins over a coincident wrap.
//  - Enable drop mid-period: next edge IDLE, outputs 0, no partial tick.
//  - i_reset asserted mid-operation: immediate async clear to reset state.
// CONFIGURATION
//  TICK_DIV_ONESHOT_EN defined: adds input i_oneshot [NUM_CH]; FSM gains DONE.
//    RUN -> DONE after first tick when i_oneshot[n]=1; DONE holds outputs 0 and
//    counter 0 until i_enable[n]=0 (-> IDLE); re-arm requires enable low then high.
//    i_sync ignored in DONE.
//  Not defined: no i_oneshot port, no DONE state; channels free-run while enabled.
// STRUCTURE
//  - Shared package tick_div_pkg: channel state enum (IDLE, RUN, DONE), CNT_W default,
//    localparam for max NUM_CH.
//  - Sub-module tick_div_channel: one counter + shadows + FSM + output regs;
//    top generates NUM_CH instances and slices packed buses.
// TESTING
//  1 Reset: assert i_reset mid-count -> o_tick/o_wave 0 same cycle, counters 0.
//  2 P=3,H=2,enable ch0 -> o_tick every 4 cycles, first 4 cycles after enable;
//    o_wave pattern 1100 repeating.
//  3 P=0 ch1 -> o_tick continuously high; H=0 -> o_wave 0; H=5 -> o_wave 1.
//  4 ch0 P=9, change to P=3 at counter=2 -> current period ends after 10 cycles,
//    subsequent periods 4 cycles; no runt tick.
//  5 ch0 P=4, ch1 P=6 running, pulse i_sync -> both counters 0 next edge, no tick
//    that edge, ticks then 5 and 7 cycles later; IDLE ch2 stays 0.
//  6 TICK_DIV_ONESHOT_EN, i_oneshot[0]=1, P=2 -> exactly one tick 3 cycles after
//    enable, then none; enable low/high -> one more tick.

Source files
------------

// File: rtl/tick_div_pkg.sv
// Shared types and limits for the tick divider bank and its channels.
package tick_div_pkg;

    localparam int MAX_CH        = 16;
    localparam int CNT_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_t;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, shadowed period/high-time, FSM and registered outputs.
// TICK_DIV_ONESHOT_EN adds a oneshot input and the DONE state.
module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             enable,
    input  logic             sync,
`ifdef TICK_DIV_ONESHOT_EN
    input  logic             oneshot,
`endif
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             tick,
    output logic             wave
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    chan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sh_p;
    logic [CNT_W-1:0] sh_h;
    logic [CNT_W-1:0] cnt_inc;
    logic             load_wave;

    assign cnt_inc   = cnt + ONE;
    // Wave value for phase 0 of a freshly loaded period.
    assign load_wave = (high != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sh_p  <= '0;
            sh_h  <= '0;
            tick  <= 1'b0;
            wave  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wave <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        state <= ST_RUN;
                        sh_p  <= period;
                        sh_h  <= high;
                        wave  <= load_wave;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (sync) begin
                        // Sync outranks a coincident wrap: restart without a tick.
                        cnt  <= '0;
                        sh_p <= period;
                        sh_h <= high;
                        wave <= load_wave;
                    end else if (cnt == sh_p) begin
                        cnt  <= '0;
                        sh_p <= period;
                        sh_h <= high;
                        tick <= 1'b1;
                        wave <= load_wave;
`ifdef TICK_DIV_ONESHOT_EN
                        if (oneshot) begin
                            state <= ST_DONE;
                            wave  <= 1'b0;
                        end
`endif
                    end else begin
                        cnt  <= cnt_inc;
                        wave <= (cnt_inc < sh_h);
                    end
                end
`ifdef TICK_DIV_ONESHOT_EN
                ST_DONE: begin
                    cnt <= '0;
                    if (!enable) state <= ST_IDLE;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of NUM_CH programmable tick/square-wave dividers sharing one sync pulse.
// Optional one-shot mode is built when TICK_DIV_ONESHOT_EN is defined.
module tick_divider_bank
    import tick_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_CH-1:0]       i_enable,
    input  logic [NUM_CH*CNT_W-1:0] i_period,
    input  logic [NUM_CH*CNT_W-1:0] i_high,
    input  logic                    i_sync,
`ifdef TICK_DIV_ONESHOT_EN
    input  logic [NUM_CH-1:0]       i_oneshot,
`endif
    output logic [NUM_CH-1:0]       o_tick,
    output logic [NUM_CH-1:0]       o_wave
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH || CNT_W < 2 || CNT_W > 32) begin : g_bad_cfg
        $error("tick_divider_bank: NUM_CH or CNT_W out of range");
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        tick_div_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .enable  (i_enable[n]),
            .sync    (i_sync),
`ifdef TICK_DIV_ONESHOT_EN
            .oneshot (i_oneshot[n]),
`endif
            .period  (i_period[n*CNT_W +: CNT_W]),
            .high    (i_high[n*CNT_W +: CNT_W]),
            .tick    (o_tick[n]),
            .wave    (o_wave[n])
        );
    end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: directed scenarios plus randomized
// traffic against a phase-based reference model.
`timescale 1ns/1ps
module tb_tick_divider_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;

    logic                    i_clk = 1'b0;
    logic                    i_reset;
    logic [NUM_CH-1:0]       i_enable;
    logic [NUM_CH*CNT_W-1:0] i_period;
    logic [NUM_CH*CNT_W-1:0] i_high;
    logic                    i_sync;
`ifdef TICK_DIV_ONESHOT_EN
    logic [NUM_CH-1:0]       i_oneshot;
`endif
    logic [NUM_CH-1:0]       o_tick;
    logic [NUM_CH-1:0]       o_wave;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    // Reference model: phase within period, period length, high time.
    bit                m_run  [NUM_CH];
    bit                m_done [NUM_CH];
    longint            m_ph   [NUM_CH];
    longint            m_len  [NUM_CH];
    longint            m_hi   [NUM_CH];
    logic [NUM_CH-1:0] exp_tick;
    logic [NUM_CH-1:0] exp_wave;

    tick_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_period (i_period),
        .i_high   (i_high),
        .i_sync   (i_sync),
`ifdef TICK_DIV_ONESHOT_EN
        .i_oneshot(i_oneshot),
`endif
        .o_tick   (o_tick),
        .o_wave   (o_wave)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    task automatic model_clear();
        for (int n = 0; n < NUM_CH; n++) begin
            m_run[n] = 0; m_done[n] = 0; m_ph[n] = 0; m_len[n] = 1; m_hi[n] = 0;
        end
        exp_tick = '0;
        exp_wave = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int n, input longint p, input longint h);
        i_period[n*CNT_W +: CNT_W] = CNT_W'(p);
        i_high[n*CNT_W +: CNT_W]   = CNT_W'(h);
    endtask

    // One clock edge; the model consumes the inputs present at that edge.
    task automatic cycle();
        logic [NUM_CH-1:0]       en;
        logic [NUM_CH*CNT_W-1:0] per, hig;
        logic                    sy;
        logic [NUM_CH-1:0]       os;
        longint                  p, h;
        en = i_enable; per = i_period; hig = i_high; sy = i_sync; os = '0;
`ifdef TICK_DIV_ONESHOT_EN
        os = i_oneshot;
`endif
        @(posedge i_clk);
        for (int n = 0; n < NUM_CH; n++) begin
            p = longint'(per[n*CNT_W +: CNT_W]);
            h = longint'(hig[n*CNT_W +: CNT_W]);
            exp_tick[n] = 1'b0;
            if (!en[n]) begin
                m_run[n] = 0; m_done[n] = 0; m_ph[n] = 0;
            end else if (m_done[n]) begin
                m_ph[n] = 0;
            end else if (!m_run[n] || sy) begin
                m_run[n] = 1; m_ph[n] = 0; m_len[n] = p + 1; m_hi[n] = h;
            end else begin
                m_ph[n]++;
                if (m_ph[n] == m_len[n]) begin
                    exp_tick[n] = 1'b1;
                    m_ph[n] = 0; m_len[n] = p + 1; m_hi[n] = h;
                    if (os[n]) begin m_done[n] = 1; m_run[n] = 0; end
                end
            end
            exp_wave[n] = m_run[n] && (m_ph[n] < m_hi[n]);
        end
        #1;
    endtask

    task automatic idle_all();
        i_enable = '0; i_sync = 1'b0; i_period = '0; i_high = '0;
`ifdef TICK_DIV_ONESHOT_EN
        i_oneshot = '0;
`endif
        cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks += 2;
        if (o_tick !== '0) begin failures++; $display("FAIL reset_tick got=%b exp=%b", o_tick, 4'b0); end
        if (o_wave !== '0) begin failures++; $display("FAIL reset_wave got=%b exp=%b", o_wave, 4'b0); end
        set_ch(0, 5, 6);
        i_enable[0] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (o_wave !== exp_wave) begin failures++; $display("FAIL reset_prerun_wave got=%b exp=%b", o_wave, exp_wave); end
        #3 i_reset = 1'b1;
        #1;
        checks += 3;
        if (o_tick !== '0) begin failures++; $display("FAIL reset_async_tick got=%b exp=0", o_tick); end
        if (o_wave !== '0) begin failures++; $display("FAIL reset_async_wave got=%b exp=0", o_wave); end
        if (dut.g_ch[0].u_ch.cnt !== '0) begin
            failures++; $display("FAIL reset_async_cnt got=%0d exp=0", dut.g_ch[0].u_ch.cnt);
        end
        i_enable = '0; i_period = '0; i_high = '0;
        model_clear();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [1:0] e;
        for (int k = 0; k < 16; k++) exp_q.push_back({(k > 0 && k % 4 == 0), (k % 4 < 2)});
        set_ch(0, 3, 2);
        i_enable[0] = 1'b1;
        while (exp_q.size() > 0) begin
            cycle();
            e = exp_q.pop_front();
            checks += 2;
            if ({o_tick[0], o_wave[0]} !== e) begin
                failures++; $display("FAIL basic_pattern got=%b exp=%b", {o_tick[0], o_wave[0]}, e);
            end
            if ({o_tick, o_wave} !== {exp_tick, exp_wave}) begin
                failures++; $display("FAIL basic_model got=%b/%b exp=%b/%b", o_tick, o_wave, exp_tick, exp_wave);
            end
        end
        idle_all();
    endtask

    task automatic test_p0();
        set_ch(1, 0, 0);
        i_enable[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks += 2;
            if (o_tick[1] !== (k > 0)) begin failures++; $display("FAIL p0_tick k=%0d got=%b exp=%b", k, o_tick[1], (k > 0)); end
            if (o_wave[1] !== 1'b0) begin failures++; $display("FAIL p0_wave_h0 got=%b exp=0", o_wave[1]); end
        end
        set_ch(1, 0, 5);
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks += 2;
            if (o_tick[1] !== 1'b1) begin failures++; $display("FAIL p0_tick_h5 got=%b exp=1", o_tick[1]); end
            if (o_wave[1] !== 1'b1) begin failures++; $display("FAIL p0_wave_h5 got=%b exp=1", o_wave[1]); end
        end
        // Boundary: H far beyond P+1 keeps wave high.
        set_ch(3, 2, 24'hFFFFFF);
        i_enable[3] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle();
            checks++;
            if (o_wave[3] !== 1'b1) begin failures++; $display("FAIL hmax_wave got=%b exp=1", o_wave[3]); end
        end
        idle_all();
    endtask

    task automatic test_reload();
        logic e;
        set_ch(0, 9, 4);
        i_enable[0] = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            if (k == 3) set_ch(0, 3, 1);
            cycle();
            e = (k == 10 || k == 14 || k == 18 || k == 22);
            checks += 2;
            if (o_tick[0] !== e) begin failures++; $display("FAIL reload_tick k=%0d got=%b exp=%b", k, o_tick[0], e); end
            if (o_wave !== exp_wave) begin failures++; $display("FAIL reload_wave k=%0d got=%b exp=%b", k, o_wave, exp_wave); end
        end
        idle_all();
    endtask

    task automatic test_sync();
        set_ch(0, 4, 2);
        set_ch(1, 6, 3);
        set_ch(2, 1, 1);
        i_enable = 4'b0011;
        for (int k = 0; k < 3; k++) cycle();
        i_sync = 1'b1;
        cycle();
        i_sync = 1'b0;
        checks++;
        if (o_tick !== '0) begin failures++; $display("FAIL sync_edge_tick got=%b exp=0", o_tick); end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            checks += 4;
            if (o_tick[0] !== (k == 5)) begin failures++; $display("FAIL sync_ch0_tick k=%0d got=%b exp=%b", k, o_tick[0], (k == 5)); end
            if (o_tick[1] !== (k == 7)) begin failures++; $display("FAIL sync_ch1_tick k=%0d got=%b exp=%b", k, o_tick[1], (k == 7)); end
            if ({o_tick[2], o_wave[2]} !== 2'b00) begin failures++; $display("FAIL sync_idle_ch2 got=%b exp=00", {o_tick[2], o_wave[2]}); end
            if (o_wave !== exp_wave) begin failures++; $display("FAIL sync_wave k=%0d got=%b exp=%b", k, o_wave, exp_wave); end
        end
        // Sync landing exactly on a wrap edge: no tick.
        set_ch(0, 2, 1);
        i_enable = 4'b0001;
        cycle(); cycle(); cycle();
        for (int k = 0; k < 4; k++) cycle();
        i_sync = 1'b1;
        cycle();
        i_sync = 1'b0;
        checks++;
        if (o_tick !== exp_tick) begin failures++; $display("FAIL sync_wrap_tick got=%b exp=%b", o_tick, exp_tick); end
        idle_all();
    endtask

`ifdef TICK_DIV_ONESHOT_EN
    task automatic test_oneshot();
        set_ch(0, 2, 1);
        i_oneshot[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            i_enable[0] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                cycle();
                checks += 2;
                if (o_tick[0] !== (k == 3)) begin failures++; $display("FAIL oneshot_tick r=%0d k=%0d got=%b exp=%b", r, k, o_tick[0], (k == 3)); end
                if (o_wave !== exp_wave) begin failures++; $display("FAIL oneshot_wave got=%b exp=%b", o_wave, exp_wave); end
            end
            i_enable[0] = 1'b0;
            cycle();
        end
        idle_all();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if ($urandom_range(9, 0) == 0) i_enable[n] = ~i_enable[n];
                if ($urandom_range(5, 0) == 0) set_ch(n, $urandom_range(7, 0), $urandom_range(10, 0));
`ifdef TICK_DIV_ONESHOT_EN
                if ($urandom_range(15, 0) == 0) i_oneshot[n] = ~i_oneshot[n];
`endif
            end
            i_sync = ($urandom_range(11, 0) == 0);
            cycle();
            checks += 2;
            if (o_tick !== exp_tick) begin failures++; $display("FAIL random_tick k=%0d got=%b exp=%b", k, o_tick, exp_tick); end
            if (o_wave !== exp_wave) begin failures++; $display("FAIL random_wave k=%0d got=%b exp=%b", k, o_wave, exp_wave); end
        end
        idle_all();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        i_reset = 1'b1;
        i_enable = '0; i_period = '0; i_high = '0; i_sync = 1'b0;
`ifdef TICK_DIV_ONESHOT_EN
        i_oneshot = '0;
`endif
        model_clear();
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        test_reset();
        test_basic();
        test_p0();
        test_reload();
        test_sync();
`ifdef TICK_DIV_ONESHOT_EN
        test_oneshot();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
